// File: rtl/pic_port_monitor.sv
// Port change monitor for the PIC core: timestamps value changes on
// ports A/B/C and queues them in a show-ahead FIFO drained via valid/ready.
module pic_port_monitor #(
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PORT_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PORT_WIDTH-1:0]         port_a,
  input  logic [PORT_WIDTH-1:0]         port_b,
  input  logic [PORT_WIDTH-1:0]         port_c,
  input  logic                          enable,
  input  logic                          clear_overflow,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [2:0]                    ev_mask,
  output logic [3*PORT_WIDTH-1:0]       ev_data,
  output logic [TS_WIDTH-1:0]           ev_time,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 3 * PORT_WIDTH;
  localparam int RW = 3 + DW + TS_WIDTH;

  logic [DW-1:0]       cur_q, cur_d;
  logic [DW-1:0]       prev_q, prev_d;
  logic                cur_vld_q, cur_vld_d;
  logic                armed_q, armed_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [AW:0]         wr_q, wr_d;
  logic [AW:0]         rd_q, rd_d;
  logic                ovf_q, ovf_d;
  logic [RW-1:0]       mem_q [FIFO_DEPTH];
  logic [RW-1:0]       mem_d [FIFO_DEPTH];

  logic [2:0]  diff;
  logic [AW:0] lvl;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        wr_en;
  logic        drop;
  logic [RW-1:0] head;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      diff[i] = cur_q[i*PORT_WIDTH +: PORT_WIDTH]
             != prev_q[i*PORT_WIDTH +: PORT_WIDTH];
    end
    lvl   = wr_q - rd_q;
    full  = lvl == (AW+1)'(FIFO_DEPTH);
    empty = lvl == '0;
    pop   = !empty && ev_ready;
    push  = armed_q && enable && (diff != 3'b000);
    // when full, a same-cycle pop frees the slot being written
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;

    cur_d     = {port_c, port_b, port_a};
    cur_vld_d = 1'b1;
    prev_d    = cur_q;
    armed_d   = armed_q || cur_vld_q;
    ts_d      = ts_q + TS_WIDTH'(1);
    wr_d      = wr_q + (AW+1)'(wr_en);
    rd_d      = rd_q + (AW+1)'(pop);
    ovf_d     = drop || (ovf_q && !clear_overflow);
    mem_d     = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = {diff, cur_q, ts_q};

    head     = mem_q[rd_q[AW-1:0]];
    ev_valid = !empty;
    {ev_mask, ev_data, ev_time} = ev_valid ? head : '0;
    level    = lvl;
    overflow = ovf_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_q     <= '0;
      prev_q    <= '0;
      cur_vld_q <= 1'b0;
      armed_q   <= 1'b0;
      ts_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      cur_vld_q <= cur_vld_d;
      armed_q   <= armed_d;
      ts_q      <= ts_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: doc/pic_port_monitor.md
Name: pic_port_monitor

Overview:
- Observer for the PIC core's output ports; consumes what `pic_core` drives on `port_a`, `port_b` and `port_c`.
- Detects value changes on any port and records each as an event: change mask, all three port values, cycle timestamp.
- Events are held in a show-ahead FIFO and drained over a valid/ready interface by a logger or scoreboard.
- Sits beside `pic_core` in benches and debug builds; fully synthesizable.

Parameters:
- `TS_WIDTH`, 16: width of the free-running cycle timestamp counter.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, minimum 2.
- `PORT_WIDTH`, 8: width of each observed port.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `port_a`  in  `PORT_WIDTH`  observed port A.
- `port_b`  in  `PORT_WIDTH`  observed port B.
- `port_c`  in  `PORT_WIDTH`  observed port C.
- `enable`  in  1  1 = record events; 0 = track values only, no pushes.
- `clear_overflow`  in  1  synchronous clear of `overflow`.
- `ev_valid`  out  1  FIFO head valid.
- `ev_ready`  in  1  consumer accepts the head when `ev_valid` is high.
- `ev_mask`  out  3  bit0 = A changed, bit1 = B changed, bit2 = C changed.
- `ev_data`  out  `3*PORT_WIDTH`  {C,B,A} values after the change.
- `ev_time`  out  `TS_WIDTH`  timestamp of the detection cycle.
- `overflow`  out  1  sticky; set when an event is dropped.
- `level`  out  `log2(FIFO_DEPTH)+1`  current FIFO occupancy.

Behaviour:
- Reset (`reset`=0, asynchronous), all outputs 0:
  - `ev_valid`, `ev_mask`, `ev_data`, `ev_time`, `overflow`, `level` = 0.
  - FIFO pointers, timestamp counter, sample/previous registers and `armed` flag cleared.
- Reset asserted mid-operation discards all queued events.
- Timestamp: `ts` = 0 in the first cycle after reset release, +1 every cycle, wraps 2^`TS_WIDTH`-1 → 0 silently.
- Sampling pipeline:
  - Edge k: ports registered into `cur`.
  - Edge k+1: `cur` copied into `prev`.
  - In the cycle `cur` holds the new value, `diff` = per-port (`cur` != `prev`).
- Baseline:
  - `armed` = 0 after reset; set at the edge where `prev` first loads a valid `cur`.
  - No event while `armed` = 0, so reset values never generate events.
- Event generation:
  - Push when `armed` & `enable` & (`diff` != 0).
  - Record = {`diff`, `cur` C/B/A, `ts` of that cycle}.
  - One record per cycle; simultaneous changes on several ports share one record with several mask bits.
- Latency: port input changes before edge k → record pushed at edge k+1 → `ev_valid` high after edge k+1 if the FIFO was empty. Two cycles in total.
- `enable` = 0: `prev`/`cur` keep tracking, so re-enabling never reports stale changes.
- Handshake:
  - Pop at an edge where `ev_valid` & `ev_ready`.
  - `ev_*` reflect the FIFO head and are held stable while `ev_valid` & !`ev_ready`.
  - `ev_ready` while `ev_valid` = 0 has no effect.
- Full FIFO:
  - Push with `level` = `FIFO_DEPTH` and no pop that cycle → record dropped, `overflow` set.
  - Push and pop in the same cycle when full → both succeed, `level` unchanged, no overflow.
- Empty FIFO: push and pop cannot coincide on the same entry; head becomes visible the cycle after the push.
- `overflow`:
  - Cleared by `clear_overflow` = 1.
  - If a drop occurs in the same cycle as `clear_overflow`, set wins.
- Pointers: `log2(FIFO_DEPTH)+1` bits with wrap bit; `level` = `wr_ptr` - `rd_ptr`.

Test Plan:
- Reset sequence: hold `reset` = 0 for 10 cycles with ports = 0x00, then release, `enable` = 1, ports static → `ev_valid` stays 0 and `level` = 0 for 50 cycles.
- Single change: at cycle 20 drive `port_b` 0x00 → 0x5A, `ev_ready` = 1 → one event, `ev_mask` = 3'b010, `ev_data` = 0x005A00, `ev_time` = the detection-cycle `ts`, `ev_valid` high 2 cycles after the input change.
- Simultaneous change: `port_a` → 0x11 and `port_c` → 0x33 in the same cycle → one event, `ev_mask` = 3'b101, `ev_data` = 0x330011.
- Overflow: `ev_ready` = 0, toggle `port_a` every cycle for 10 cycles (`FIFO_DEPTH` = 8) → `level` = 8, `overflow` = 1. Then drain → exactly 8 events with consecutive `ev_time` values. Pulse `clear_overflow` → `overflow` = 0.
- Full push+pop: with `level` = 8, assert `ev_ready` in the same cycle as a new change → `level` stays 8, `overflow` stays 0, new event appears last.
- Reset mid-operation: with 5 events queued, assert `reset` = 0 for 1 cycle → `ev_valid` = 0 and `level` = 0 immediately (asynchronous), no event for the unchanged port values after release, `ts` restarts at 0.
